// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial transmitter and its FIFO.
package serial_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} serial_tx_state_t;

  // Clock cycles per bit, rounded to the nearest integer.
  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with pointer wrap and an explicit occupancy count.
// Head data is presented combinationally so a pop and a load can happen on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  // A full FIFO refuses a push even if a pop happens on the same edge.
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  // Storage write; contents need no reset since the count gates every read.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/serial_tx.sv
// Buffered 8N1 serial transmitter: FIFO front end, then start/data/stop framing
// at a fixed integer baud divisor. Back-to-back bytes are sent with no idle gap.
module serial_tx
  import serial_pkg::*;
#(
  parameter int CLK_HZ     = 160_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clock_160,
  input  logic                          inp_resn,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx_out,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int DIV = baud_div(CLK_HZ, BAUD);
  localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [CW-1:0] DIV_M1    = CW'(DIV - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  if (DIV < 2) begin : g_bad_div
    $error("serial_tx: baud divisor must be at least 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("serial_tx: STOP_BITS must be 1 or 2");
  end

  serial_tx_state_t r_state, w_state;
  logic [CW-1:0]    r_baud, w_baud;
  logic [2:0]       r_bit, w_bit;
  logic [7:0]       r_shift, w_shift;
  logic             r_tx, w_tx;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [7:0]       w_head;
  logic             w_baud_end;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (clock_160),
    .i_rst_n (inp_resn),
    .i_push  (tx_valid),
    .i_data  (tx_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (fifo_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign tx_ready   = ~w_full;
  assign tx_out     = r_tx;
  assign tx_busy    = (r_state != IDLE) | (fifo_count != '0);
  assign w_baud_end = (r_baud == DIV_M1);

  // Framing state machine: next state, counters, shift register and line level.
  always_comb begin
    w_state = r_state;
    w_baud  = r_baud;
    w_bit   = r_bit;
    w_shift = r_shift;
    w_tx    = r_tx;
    w_pop   = 1'b0;
    case (r_state)
      IDLE: begin
        w_baud = '0;
        w_bit  = '0;
        w_tx   = 1'b1;
        if (!w_empty) begin
          w_pop   = 1'b1;
          w_shift = w_head;
          w_tx    = 1'b0;
          w_state = START;
        end
      end
      START: begin
        if (w_baud_end) begin
          w_state = DATA;
          w_baud  = '0;
          w_bit   = '0;
          w_tx    = r_shift[0];
        end else begin
          w_baud = r_baud + 1'b1;
        end
      end
      DATA: begin
        if (w_baud_end) begin
          w_baud = '0;
          if (r_bit == 3'd7) begin
            w_state = STOP;
            w_bit   = '0;
            w_tx    = 1'b1;
          end else begin
            w_bit   = r_bit + 1'b1;
            w_shift = r_shift >> 1;
            w_tx    = r_shift[1];
          end
        end else begin
          w_baud = r_baud + 1'b1;
        end
      end
      STOP: begin
        if (w_baud_end) begin
          w_baud = '0;
          if (r_bit == STOP_LAST) begin
            w_bit = '0;
            // Chain straight into the next start bit when more data is queued.
            if (!w_empty) begin
              w_pop   = 1'b1;
              w_shift = w_head;
              w_tx    = 1'b0;
              w_state = START;
            end else begin
              w_tx    = 1'b1;
              w_state = IDLE;
            end
          end else begin
            w_bit = r_bit + 1'b1;
          end
        end else begin
          w_baud = r_baud + 1'b1;
        end
      end
      default: begin
        w_state = IDLE;
        w_tx    = 1'b1;
      end
    endcase
  end

  // State and datapath registers; reset forces the line high immediately.
  always_ff @(posedge clock_160 or negedge inp_resn) begin
    if (!inp_resn) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state;
      r_baud  <= w_baud;
      r_bit   <= w_bit;
      r_shift <= w_shift;
      r_tx    <= w_tx;
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: a line monitor decodes frames into a queue which is
// compared against bytes recorded when they were pushed.
module tb_serial_tx;

  localparam int DIV = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b1;

  logic [7:0] a_data = '0;
  logic       a_valid = 1'b0;
  logic       a_ready, a_tx, a_busy;
  logic [2:0] a_cnt;

  logic [7:0] b_data = '0;
  logic       b_valid = 1'b0;
  logic       b_ready, b_tx, b_busy;
  logic [4:0] b_cnt;

  logic [7:0] c_data = '0;
  logic       c_valid = 1'b0;
  logic       c_ready, c_tx, c_busy;
  logic [4:0] c_cnt;

  serial_tx #(.CLK_HZ(1_600_000), .BAUD(100_000), .FIFO_DEPTH(4), .STOP_BITS(1)) dut_a (
    .clock_160(clk), .inp_resn(rst_n), .tx_data(a_data), .tx_valid(a_valid),
    .tx_ready(a_ready), .tx_out(a_tx), .tx_busy(a_busy), .fifo_count(a_cnt));

  serial_tx #(.CLK_HZ(1_600_000), .BAUD(100_000), .FIFO_DEPTH(16), .STOP_BITS(2)) dut_b (
    .clock_160(clk), .inp_resn(rst_n), .tx_data(b_data), .tx_valid(b_valid),
    .tx_ready(b_ready), .tx_out(b_tx), .tx_busy(b_busy), .fifo_count(b_cnt));

  serial_tx dut_c (
    .clock_160(clk), .inp_resn(rst_n), .tx_data(c_data), .tx_valid(c_valid),
    .tx_ready(c_ready), .tx_out(c_tx), .tx_busy(c_busy), .fifo_count(c_cnt));

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] b;
    bit         ok;
  } frame_t;

  logic [7:0] exp_q[$];
  frame_t     got_q[$];

  // Line monitor for dut_a: sample each bit at its centre.
  bit         mon_act = 1'b0;
  int         mon_cnt = 0;
  logic [7:0] mon_b = '0;
  bit         mon_ok = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_act <= 1'b0;
    end else if (!mon_act) begin
      if (a_tx === 1'b0) begin
        mon_act <= 1'b1;
        mon_cnt <= 0;
        mon_ok  <= 1'b1;
      end
    end else begin
      mon_cnt <= mon_cnt + 1;
      if (mon_cnt + 1 == DIV / 2 && a_tx !== 1'b0) mon_ok <= 1'b0;
      if (mon_cnt + 1 > DIV / 2 && mon_cnt + 1 < DIV / 2 + 9 * DIV &&
          ((mon_cnt + 1 - DIV / 2) % DIV) == 0)
        mon_b <= {a_tx, mon_b[7:1]};
      if (mon_cnt + 1 == DIV / 2 + 9 * DIV) begin
        mon_act <= 1'b0;
        got_q.push_back(frame_t'{b: mon_b, ok: mon_ok && (a_tx === 1'b1)});
      end
    end
  end

  // Expected line level k cycles into a 1-stop frame (k=1 is the first start cycle).
  function automatic logic exp_bit(input logic [7:0] b, input int k);
    if (k <= DIV) return 1'b0;
    else if (k <= 9 * DIV) return b[3'((k - DIV - 1) / DIV)];
    else return 1'b1;
  endfunction

  // Pop decoded frames and compare with the bytes recorded at push time.
  task automatic sb_drain(input int n, input string tag);
    int waited = 0;
    frame_t f;
    logic [7:0] e;
    while (got_q.size() < n && waited < n * 200 + 100) begin
      @(negedge clk);
      waited++;
    end
    if (got_q.size() < n) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got %0d frames, want %0d", tag, got_q.size(), n);
    end
    while (got_q.size() > 0) begin
      f = got_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s_extra: unexpected frame %02h", tag, f.b);
      end else begin
        e = exp_q.pop_front();
        if (f.b !== e || !f.ok) begin
          errors++;
          $display("FAIL %s_frame: got %02h framing_ok=%0d, want %02h", tag, f.b, f.ok, e);
        end
      end
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (a_tx !== 1'b1 || a_busy !== 1'b0 || a_cnt !== 3'd0 || a_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: tx=%b busy=%b cnt=%0d ready=%b, want 1 0 0 1", a_tx, a_busy, a_cnt, a_ready);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    int bad = 0;
    a_data = 8'h55; a_valid = 1'b1; exp_q.push_back(8'h55);
    @(negedge clk); a_valid = 1'b0;
    checks++;
    if (a_tx !== 1'b1) begin errors++; $display("FAIL single_latency: tx=%b at edge N, want 1", a_tx); end
    for (int k = 1; k <= 160; k++) begin
      @(negedge clk);
      if (a_tx !== exp_bit(8'h55, k)) bad++;
      if (k == 160) begin
        checks++;
        if (a_busy !== 1'b1) begin errors++; $display("FAIL single_busy_hold: busy=%b at N+160, want 1", a_busy); end
      end
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL single_wave: %0d wrong cycles, want 0", bad); end
    @(negedge clk);
    checks++;
    if (a_busy !== 1'b0) begin errors++; $display("FAIL single_busy_fall: busy=%b at N+161, want 0", a_busy); end
    sb_drain(1, "single");
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    a_data = 8'hA5; a_valid = 1'b1; exp_q.push_back(8'hA5);
    @(negedge clk);
    a_data = 8'h3C; exp_q.push_back(8'h3C);
    @(negedge clk); a_valid = 1'b0;
    for (int k = 1; k <= 320; k++) begin
      if (k > 1) @(negedge clk);
      if (a_tx !== (k <= 160 ? exp_bit(8'hA5, k) : exp_bit(8'h3C, k - 160))) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL b2b_wave: %0d wrong cycles, want 0", bad); end
    @(negedge clk);
    checks++;
    if (a_busy !== 1'b0 || a_tx !== 1'b1) begin
      errors++; $display("FAIL b2b_end: busy=%b tx=%b, want 0 1", a_busy, a_tx);
    end
    sb_drain(2, "b2b");
  endtask

  task automatic test_backpressure();
    logic [7:0] bytes [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    int acc [6];
    int i = 0;
    int iter = 0;
    bit full_seen = 1'b0;
    bit will;
    int e;
    while (i < 6 && iter < 400) begin
      a_data = bytes[i]; a_valid = 1'b1;
      will = a_ready; e = cyc + 1;
      @(negedge clk);
      iter++;
      if (will) begin
        acc[i] = e; exp_q.push_back(bytes[i]); i++;
        if (i == 5) begin
          full_seen = 1'b1;
          checks++;
          if (a_cnt !== 3'd4 || a_ready !== 1'b0) begin
            errors++; $display("FAIL bp_full: cnt=%0d ready=%b, want 4 0", a_cnt, a_ready);
          end
        end
      end
    end
    a_valid = 1'b0;
    checks++;
    if (i != 6 || !full_seen) begin
      errors++; $display("FAIL bp_accept: accepted %0d bytes, want 6", i);
    end else begin
      checks++;
      if (acc[4] - acc[0] != 4) begin
        errors++; $display("FAIL bp_burst: first 5 spanned %0d edges, want 4", acc[4] - acc[0]);
      end
      checks++;
      if (acc[5] - acc[0] != 162) begin
        errors++; $display("FAIL bp_sixth: 6th accepted %0d edges after 1st, want 162", acc[5] - acc[0]);
      end
    end
    sb_drain(6, "bp");
  endtask

  task automatic test_stop2();
    int bad = 0;
    b_data = 8'hFF; b_valid = 1'b1;
    @(negedge clk);
    b_data = 8'h7E;
    @(negedge clk); b_valid = 1'b0;
    for (int k = 1; k <= 176; k++) begin
      if (k > 1) @(negedge clk);
      if (b_tx !== (k <= DIV ? 1'b0 : 1'b1)) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL stop2_wave: %0d wrong cycles, want 0", bad); end
    @(negedge clk);
    checks++;
    if (b_tx !== 1'b0) begin errors++; $display("FAIL stop2_next_start: tx=%b at 177, want 0", b_tx); end
    repeat (200) @(negedge clk);
    checks++;
    if (b_busy !== 1'b0 || b_tx !== 1'b1) begin
      errors++; $display("FAIL stop2_idle: busy=%b tx=%b, want 0 1", b_busy, b_tx);
    end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    a_data = 8'h00; a_valid = 1'b1; exp_q.push_back(8'h00);
    @(negedge clk);
    a_data = 8'h11; exp_q.push_back(8'h11);
    @(negedge clk); a_valid = 1'b0;
    repeat (69) @(negedge clk);
    checks++;
    if (a_tx !== 1'b0) begin errors++; $display("FAIL rst_mid_bit3: tx=%b before reset, want 0", a_tx); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (a_tx !== 1'b1 || a_cnt !== 3'd0 || a_busy !== 1'b0 || a_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_async: tx=%b cnt=%0d busy=%b ready=%b, want 1 0 0 1", a_tx, a_cnt, a_busy, a_ready);
    end
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 250; k++) begin
      @(negedge clk);
      if (a_tx !== 1'b1 || a_busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || got_q.size() != 0) begin
      errors++; $display("FAIL rst_mid_quiet: %0d active cycles, %0d frames, want 0 0", bad, got_q.size());
    end
    got_q.delete();
    a_data = 8'hC3; a_valid = 1'b1; exp_q.push_back(8'hC3);
    @(negedge clk); a_valid = 1'b0;
    sb_drain(1, "rst_mid_fresh");
  endtask

  task automatic test_rounding();
    int len = 0;
    c_data = 8'hFF; c_valid = 1'b1;
    @(negedge clk); c_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (c_tx !== 1'b0) begin errors++; $display("FAIL round_latency: tx=%b at N+1, want 0", c_tx); end
    while (c_tx === 1'b0 && len < 3000) begin
      len++;
      @(negedge clk);
    end
    checks++;
    if (len != 1389) begin errors++; $display("FAIL round_start_len: %0d cycles, want 1389", len); end
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_single();
    @(negedge clk);
    test_back_to_back();
    @(negedge clk);
    test_backpressure();
    repeat (20) @(negedge clk);
    test_stop2();
    @(negedge clk);
    test_reset_mid();
    repeat (20) @(negedge clk);
    test_rounding();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
